// File: rtl/demux1_10_deser.sv
// Receiving end of a 10:1 select-driven serial path: assembles one 10-bit word from per-slot bits.
// Define DEMUX_STRICT_ORDER_EN to require slots in order 0..9; the default build accepts any order.
module demux1_10_deser (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in,
    input  logic [3:0] sl,
    input  logic       valid,
    output logic [9:0] out,
    output logic       done,
    output logic       err,
    output logic [3:0] fill
);

    logic [9:0] shw;
    logic [9:0] msk;

    logic [9:0] slot_bit;
    logic       slot_legal;
    logic       order_ok;
    logic [9:0] next_shw;
    logic [9:0] next_msk;
    logic       frame_complete;

    function automatic logic [3:0] popcount10(input logic [9:0] v);
        logic [3:0] c;
        c = '0;
        for (int k = 0; k < 10; k++) begin
            c = c + {3'b000, v[k]};
        end
        return c;
    endfunction

    // NOTE: every signal written in always_comb gets a value on every path, so no latch is inferred.
    always_comb begin
        slot_bit       = 10'b1 << sl;
        slot_legal     = (sl <= 4'd9);
        next_shw       = in ? (shw | slot_bit) : (shw & ~slot_bit);
        next_msk       = msk | slot_bit;
        frame_complete = &next_msk;
    end

`ifdef DEMUX_STRICT_ORDER_EN
    assign order_ok = (sl == fill);
`else
    assign order_ok = 1'b1;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shw  <= '0;
            msk  <= '0;
            fill <= '0;
            out  <= '0;
            done <= 1'b0;
            err  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (valid) begin
                if (!slot_legal) begin
                    err <= 1'b1;
                end else if (order_ok) begin
                    if (frame_complete) begin
                        out  <= next_shw;
                        done <= 1'b1;
                        shw  <= next_shw;
                        msk  <= '0;
                        fill <= '0;
                    end else begin
                        shw  <= next_shw;
                        msk  <= next_msk;
                        fill <= popcount10(next_msk);
                    end
                end else begin
                    // Out-of-order slot: drop the frame; a slot 0 restarts it immediately.
                    err <= 1'b1;
                    if (sl == 4'd0) begin
                        shw  <= {9'b0, in};
                        msk  <= 10'b0000000001;
                        fill <= 4'd1;
                    end else begin
                        shw  <= '0;
                        msk  <= '0;
                        fill <= '0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_demux1_10_deser.sv
// Self-checking bench for demux1_10_deser (default build): vector table plus a back-to-back frame sequence.
module tb_demux1_10_deser;

    logic       clk;
    logic       rst_n;
    logic       in;
    logic [3:0] sl;
    logic       valid;
    logic [9:0] out;
    logic       done;
    logic       err;
    logic [3:0] fill;

    int checks   = 0;
    int failures = 0;

    demux1_10_deser dut (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (in),
        .sl    (sl),
        .valid (valid),
        .out   (out),
        .done  (done),
        .err   (err),
        .fill  (fill)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic       valid;
        logic       in;
        logic [3:0] sl;
        logic [9:0] out;
        logic       done;
        logic       err;
        logic [3:0] fill;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic v, input logic b, input int s,
                       input logic [9:0] o, input logic d, input logic e, input int f);
        vec_t x;
        x.rst_n = r; x.valid = v; x.in = b; x.sl = 4'(s);
        x.out = o; x.done = d; x.err = e; x.fill = 4'(f);
        tbl.push_back(x);
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got out=%h done=%b err=%b fill=%0d, want out=%h done=%b err=%b fill=%0d",
                     name, act[15:6], act[5], act[4], act[3:0], exp[15:6], exp[5], exp[4], exp[3:0]);
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic b, input logic [3:0] s);
        @(negedge clk);
        rst_n = r; valid = v; in = b; sl = s;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s;
        logic [9:0] word_a;
        logic [9:0] word_b;
        logic [9:0] exp_out;

        rst_n = 1'b0; valid = 1'b0; in = 1'b0; sl = 4'd0;

        // Reset, and reset winning over a simultaneous valid write.
        add(0, 0, 0, 0, 10'h000, 0, 0, 0);
        add(0, 1, 1, 3, 10'h000, 0, 0, 0);
        // In-order frame, only slot 3 high.
        for (int i = 0; i < 10; i++)
            add(1, 1, (i == 3), i, (i == 9) ? 10'h008 : 10'h000, (i == 9), 0, (i == 9) ? 0 : i + 1);
        // Idle cycle with an illegal slot must neither flag nor change anything.
        add(1, 0, 1, 12, 10'h008, 0, 0, 0);
        // Reverse order 9..0 with in = sl[0].
        for (int i = 0; i < 10; i++) begin
            s = 9 - i;
            add(1, 1, s[0], s, (i == 9) ? 10'h2AA : 10'h008, (i == 9), 0, (i == 9) ? 0 : i + 1);
        end
        // Illegal slot after 4 slots: err sticks, fill and out hold, frame still completes.
        for (int i = 0; i < 4; i++)
            add(1, 1, 1, i, 10'h2AA, 0, 0, i + 1);
        add(1, 1, 1, 12, 10'h2AA, 0, 1, 4);
        for (int i = 4; i < 10; i++)
            add(1, 1, 0, i, (i == 9) ? 10'h00F : 10'h2AA, (i == 9), 1, (i == 9) ? 0 : i + 1);
        add(1, 0, 0, 0, 10'h00F, 0, 1, 0);
        add(0, 0, 0, 0, 10'h000, 0, 0, 0);
        // Slot 5 rewritten 1 -> 0; fill does not grow on the rewrite.
        add(1, 1, 1, 5, 10'h000, 0, 0, 1);
        add(1, 1, 0, 5, 10'h000, 0, 0, 1);
        for (int j = 0; j < 9; j++) begin
            s = (j < 5) ? j : j + 1;
            add(1, 1, 1, s, (j == 8) ? 10'h3DF : 10'h000, (j == 8), 0, (j == 8) ? 0 : j + 2);
        end
        // Reset after 7 slots discards the partial frame.
        for (int i = 0; i < 7; i++)
            add(1, 1, 1, i, 10'h3DF, 0, 0, i + 1);
        add(0, 1, 1, 7, 10'h000, 0, 0, 0);
        for (int i = 0; i < 10; i++)
            add(1, 1, 1, i, (i == 9) ? 10'h3FF : 10'h000, (i == 9), 0, (i == 9) ? 0 : i + 1);

        foreach (tbl[i]) begin
            drive(tbl[i].rst_n, tbl[i].valid, tbl[i].in, tbl[i].sl);
            check($sformatf("vec%0d", i), {out, done, err, fill},
                  {tbl[i].out, tbl[i].done, tbl[i].err, tbl[i].fill});
        end

        // Two frames on 20 consecutive valid cycles: done only on cycles 10 and 20.
        word_a = 10'h155;
        word_b = 10'h2AA;
        exp_out = 10'h3FF;
        for (int c = 1; c <= 20; c++) begin
            s = (c - 1) % 10;
            drive(1'b1, 1'b1, (c <= 10) ? word_a[s] : word_b[s], 4'(s));
            if (c == 10) exp_out = word_a;
            if (c == 20) exp_out = word_b;
            check($sformatf("b2b_cycle%0d", c), {out, done, err, fill},
                  {exp_out, (c == 10 || c == 20), 1'b0, 4'((c % 10 == 0) ? 0 : c % 10)});
        end
        // Done is a single-cycle pulse; out holds afterwards.
        drive(1'b1, 1'b0, 1'b0, 4'd0);
        check("b2b_after", {out, done, err, fill}, {word_b, 1'b0, 1'b0, 4'd0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
